alu_mode_sequencer: RTL and testbench

ALU_MODE_SEQUENCER -- requirements
Module: alu_mode_sequencer

---
 rtl/alu_mode_sequencer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_alu_mode_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mode_sequencer.sv
// Button-driven ALU: debounced mode select (0..9), start-triggered op, N-cycle restoring divide.
// Latency: done pulses 2 cycles after start is accepted, N+1 for DIV/MOD; seven-segment decode under ALU_DISPLAY_EN.
// Backpressure: start is only sampled while idle; mode edges arriving while busy are dropped.
module alu_mode_sequencer #(
    parameter int N          = 4,
    parameter int DEB_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mode_btn,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic [3:0]   flags,
    output logic [3:0]   mode,
    output logic         busy,
    output logic         done,
    output logic [6:0]   disp_mode,
    output logic [6:0]   disp_res_hi,
    output logic [6:0]   disp_res_lo
);

    localparam int DW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DIVIDE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            deb_level_q, deb_level_d;
    logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
    logic            deb_rise;
    logic [3:0]      mode_q, mode_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [3:0]      op_q, op_d;
    logic [N-1:0]    rem_q, rem_d;
    logic [N-1:0]    quo_q, quo_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [N-1:0]    result_q, result_d;
    logic [3:0]      flags_q, flags_d;

    logic [N:0]      add_w;
    logic [N-1:0]    sub_w;
    logic [2*N-1:0]  mul_w;
    logic [N:0]      shl_w;
    logic [N:0]      shr_w;
    logic [N-1:0]    alu_res;
    logic            alu_c;
    logic            alu_v;

    logic [N:0]      rem_sh;
    logic            div_ge;
    logic [N-1:0]    rem_nx;
    logic [N-1:0]    quo_nx;
    logic [N-1:0]    div_fin;

    // Debouncer flips only after DEB_CYCLES consecutive samples disagreeing with the held level.
    always_comb begin
        sync1_d     = mode_btn;
        sync2_d     = sync1_q;
        deb_level_d = deb_level_q;
        deb_cnt_d   = '0;
        deb_rise    = 1'b0;
        if (sync2_q != deb_level_q) begin
            if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
                deb_level_d = sync2_q;
                deb_rise    = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Mode only advances while idle; an edge coinciding with start still counts.
    always_comb begin
        mode_d = mode_q;
        if (deb_rise && (state_q == S_IDLE)) begin
            mode_d = (mode_q == 4'd9) ? 4'd0 : mode_q + 4'd1;
        end
    end

    assign add_w = {1'b0, a_q} + {1'b0, b_q};
    assign sub_w = a_q - b_q;
    assign mul_w = {{N{1'b0}}, a_q} * {{N{1'b0}}, b_q};
    assign shl_w = {1'b0, a_q} << b_q;
    assign shr_w = {a_q, 1'b0} >> b_q;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = add_w[N-1:0];
                alu_c   = add_w[N];
                alu_v   = (a_q[N-1] == b_q[N-1]) && (add_w[N-1] != a_q[N-1]);
            end
            OP_SUB: begin
                alu_res = sub_w;
                alu_c   = (a_q < b_q);
                alu_v   = (a_q[N-1] != b_q[N-1]) && (sub_w[N-1] != a_q[N-1]);
            end
            OP_MUL: begin
                alu_res = mul_w[N-1:0];
                alu_c   = |mul_w[2*N-1:N];
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            // The extra bit beside the operand catches the last bit shifted out.
            OP_SHL: begin
                alu_res = shl_w[N-1:0];
                alu_c   = shl_w[N];
            end
            OP_SHR: begin
                alu_res = shr_w[N:1];
                alu_c   = shr_w[0];
            end
            default: ;
        endcase
    end

    // One restoring step per cycle; divisor 0 naturally yields all-ones quotient and remainder a.
    always_comb begin
        rem_sh  = {rem_q, quo_q[N-1]};
        div_ge  = (rem_sh >= {1'b0, b_q});
        rem_nx  = div_ge ? N'(rem_sh - {1'b0, b_q}) : rem_sh[N-1:0];
        quo_nx  = {quo_q[N-2:0], div_ge};
        div_fin = (op_q == OP_DIV) ? quo_nx : rem_nx;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = mode_q;
                    rem_d   = '0;
                    quo_d   = a;
                    cnt_d   = '0;
                    state_d = ((mode_q == OP_DIV) || (mode_q == OP_MOD)) ? S_DIVIDE : S_EXEC;
                end
            end
            S_EXEC: begin
                result_d = alu_res;
                flags_d  = {alu_res[N-1], (alu_res == '0), alu_c, alu_v};
                state_d  = S_DONE;
            end
            S_DIVIDE: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(N - 1)) begin
                    result_d = div_fin;
                    flags_d  = {div_fin[N-1], (div_fin == '0), (b_q == '0), 1'b0};
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_level_q <= 1'b0;
            deb_cnt_q   <= '0;
            mode_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_level_q <= deb_level_d;
            deb_cnt_q   <= deb_cnt_d;
            mode_q      <= mode_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign result = result_q;
    assign flags  = flags_q;
    assign mode   = mode_q;
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);

`ifdef ALU_DISPLAY_EN
    // Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] on;
        case (v)
            4'h0: on = 7'b0111111;
            4'h1: on = 7'b0000110;
            4'h2: on = 7'b1011011;
            4'h3: on = 7'b1001111;
            4'h4: on = 7'b1100110;
            4'h5: on = 7'b1101101;
            4'h6: on = 7'b1111101;
            4'h7: on = 7'b0000111;
            4'h8: on = 7'b1111111;
            4'h9: on = 7'b1101111;
            4'hA: on = 7'b1110111;
            4'hB: on = 7'b1111100;
            4'hC: on = 7'b0111001;
            4'hD: on = 7'b1011110;
            4'hE: on = 7'b1111001;
            default: on = 7'b1110001;
        endcase
        return ~on;
    endfunction

    logic [7:0] res_ext;
    assign res_ext     = 8'(result_q);
    assign disp_mode   = seg7(mode_q);
    assign disp_res_hi = seg7(res_ext[7:4]);
    assign disp_res_lo = seg7(res_ext[3:0]);
`else
    assign disp_mode   = 7'b1111111;
    assign disp_res_hi = 7'b1111111;
    assign disp_res_lo = 7'b1111111;
`endif

endmodule

// File: tb/tb_alu_mode_sequencer.sv
// Bench for alu_mode_sequencer: arithmetic reference model plus per-cycle compare, directed and random ops.
module tb_alu_mode_sequencer;
    localparam int N   = 4;
    localparam int DEB = 4;
    localparam int M   = 1 << N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mode_btn = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [N-1:0] result;
    logic [3:0]   flags;
    logic [3:0]   mode;
    logic         busy;
    logic         done;
    logic [6:0]   disp_mode;
    logic [6:0]   disp_res_hi;
    logic [6:0]   disp_res_lo;

    alu_mode_sequencer #(.N(N), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .mode_btn(mode_btn), .start(start),
        .a(a), .b(b), .result(result), .flags(flags), .mode(mode),
        .busy(busy), .done(done), .disp_mode(disp_mode),
        .disp_res_hi(disp_res_hi), .disp_res_lo(disp_res_lo)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference state: committed outputs, pending completion, busy window in edge numbers.
    int cur_res = 0, cur_fl = 0, pend_res = 0, pend_fl = 0;
    bit pend_v = 1'b0;
    int acc_cyc = -100, done_cyc = -100, issue_cyc = 0;
    int exp_mode = 0;
    bit mode_chk = 1'b1;

`ifdef ALU_DISPLAY_EN
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_2 = 7'b0100100;
`else
    localparam logic [6:0] SEG_0 = 7'b1111111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_2 = 7'b1111111;
`endif

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model(input int op, input int av, input int bv, output int r, output int fl);
        int s, sa, sb, c, v;
        c = 0; v = 0; r = 0;
        sa = (av >= M/2) ? av - M : av;
        sb = (bv >= M/2) ? bv - M : bv;
        case (op)
            0: begin s = av + bv; r = s % M; c = int'(s >= M); s = sa + sb; v = int'(s > M/2-1 || s < -M/2); end
            1: begin r = (av - bv + M) % M; c = int'(av < bv); s = sa - sb; v = int'(s > M/2-1 || s < -M/2); end
            2: begin s = av * bv; r = s % M; c = int'(s >= M); end
            3: if (bv == 0) begin r = M - 1; c = 1; end else r = av / bv;
            4: if (bv == 0) begin r = av; c = 1; end else r = av % bv;
            5: r = av & bv;
            6: r = av | bv;
            7: r = av ^ bv;
            8: begin r = (bv >= N) ? 0 : (av << bv) % M; c = (bv >= 1 && bv <= N) ? (av >> (N - bv)) & 1 : 0; end
            default: begin r = (bv >= N) ? 0 : av >> bv; c = (bv >= 1 && bv <= N) ? (av >> (bv - 1)) & 1 : 0; end
        endcase
        fl = ((r >= M/2) ? 8 : 0) + ((r == 0) ? 4 : 0) + 2*c + v;
    endtask

    always @(posedge clk) begin
        cyc++;
        #2;
        if (pend_v && cyc >= done_cyc) begin
            cur_res = pend_res;
            cur_fl  = pend_fl;
            pend_v  = 1'b0;
        end
        chk("busy", int'(busy), int'(cyc >= acc_cyc && cyc <= done_cyc));
        chk("done", int'(done), int'(cyc == done_cyc));
        chk("result", int'(result), cur_res);
        chk("flags", int'(flags), cur_fl);
        if (mode_chk) chk("mode", int'(mode), exp_mode);
    end

    task automatic wait_idle();
        for (int i = 0; i < 60 && cyc <= done_cyc; i++) @(negedge clk);
        if (cyc <= done_cyc) chk("idle_timeout", 0, 1);
    endtask

    task automatic issue_op(input int av, input int bv);
        int r, fl, op, nb;
        @(negedge clk);
        wait_idle();
        a = N'(av);
        b = N'(bv);
        start = 1'b1;
        op = exp_mode;
        model(op, av, bv, r, fl);
        nb = (op == 3 || op == 4) ? N + 1 : 2;
        issue_cyc = cyc;
        acc_cyc   = cyc + 1;
        done_cyc  = acc_cyc + nb - 1;
        pend_res  = r;
        pend_fl   = fl;
        pend_v    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_lit(input string name, input int av, input int bv,
                           input int er, input int ef, input int elat, input int ebusy);
        int nbusy, lat;
        nbusy = 0;
        lat = -1;
        issue_op(av, bv);
        for (int i = 0; i < 40; i++) begin
            if (busy) nbusy++;
            if (done) lat = cyc - issue_cyc;
            if (!busy) break;
            @(negedge clk);
        end
        chk({name, "_latency"}, lat, elat);
        chk({name, "_busy_cycles"}, nbusy, ebusy);
        chk({name, "_result"}, int'(result), er);
        chk({name, "_flags"}, int'(flags), ef);
    endtask

    task automatic press(input int hold, input bit counts);
        @(negedge clk);
        wait_idle();
        mode_chk = 1'b0;
        mode_btn = 1'b1;
        repeat (hold) @(negedge clk);
        mode_btn = 1'b0;
        repeat (DEB + 6) @(negedge clk);
        if (counts) exp_mode = (exp_mode + 1) % 10;
        mode_chk = 1'b1;
        chk("mode_after_press", int'(mode), exp_mode);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (edge %0d)", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_result", int'(result), 0);
        chk("reset_mode", int'(mode), 0);
        chk("reset_disp_mode", int'(disp_mode), int'(SEG_0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ADD with signed overflow into the sign bit.
        run_lit("add_7_1", 7, 1, 8, 4'b1001, 2, 2);
        chk("disp_res_lo_8", int'(disp_res_lo), int'(SEG_8));
        chk("disp_res_hi_0", int'(disp_res_hi), int'(SEG_0));

        // Short glitch must not advance the mode.
        @(negedge clk);
        mode_btn = 1'b1;
        repeat (DEB - 1) @(negedge clk);
        mode_btn = 1'b0;
        repeat (DEB + 6) @(negedge clk);
        chk("glitch_mode", int'(mode), 0);

        repeat (3) press(DEB + 3, 1'b1);
        chk("mode_after_3", int'(mode), 3);

        run_lit("div_13_4", 13, 4, 3, 4'b0000, N + 1, N + 1);
        run_lit("div_by_0", 13, 0, 15, 4'b1010, N + 1, N + 1);
        run_lit("sub_skip", 9, 0, 15, 4'b1010, N + 1, N + 1);

        repeat (7) press(DEB + 3, 1'b1);
        chk("mode_wrap_10", int'(mode), 0);
        repeat (2) press(DEB + 3, 1'b1);
        chk("mode_mul", int'(mode), 2);
        chk("disp_mode_2", int'(disp_mode), int'(SEG_2));

        // Button edge lands while busy and a second start arrives mid-op: both dropped.
        @(negedge clk);
        mode_btn = 1'b1;
        repeat (2) @(negedge clk);
        issue_op(5, 4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        @(negedge clk);
        chk("mul_5_4_result", int'(result), 4);
        chk("mul_5_4_flags", int'(flags), 4'b0010);
        mode_btn = 1'b0;
        repeat (DEB + 6) @(negedge clk);
        chk("mode_frozen", int'(mode), 2);

        for (int it = 0; it < 60; it++) begin
            int np, av, bv;
            np = ($urandom_range(2, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
            repeat (np) press(DEB + 3, 1'b1);
            av = int'($urandom_range(M - 1, 0));
            bv = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(M - 1, 0));
            issue_op(av, bv);
            if ($urandom_range(1, 0) == 1) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end

        for (int i = 0; i < 10 && exp_mode != 3; i++) press(DEB + 3, 1'b1);
        chk("mode_before_reset", int'(mode), 3);
        issue_op(13, 4);
        @(negedge clk);
        rst_n    = 1'b0;
        acc_cyc  = -100;
        done_cyc = -100;
        pend_v   = 1'b0;
        cur_res  = 0;
        cur_fl   = 0;
        exp_mode = 0;
        #1;
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_done", int'(done), 0);
        chk("midreset_result", int'(result), 0);
        chk("midreset_flags", int'(flags), 0);
        chk("midreset_mode", int'(mode), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        run_lit("post_reset_add", 3, 4, 7, 4'b0000, 2, 2);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
